// File: rtl/glm_load.sv
// DRAM-to-BRAM load stage: decodes one instruction, launches a single DMA read
// burst and streams the returned cache lines into a selected BRAM region.
module glm_load #(
  parameter int CLADDR_WIDTH = 42,
  parameter int LOG2_DEPTH   = 10
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    op_start,
  output logic                    op_done,
  input  logic [6:0][31:0]        regs,
  input  logic [CLADDR_WIDTH-1:0] in_addr,
  input  logic [CLADDR_WIDTH-1:0] out_addr,

  output logic                    dma_rd_start,
  output logic [CLADDR_WIDTH-1:0] dma_rd_addr,
  output logic [31:0]             dma_rd_length,
  input  logic                    dma_rd_idle,
  input  logic                    dma_rd_active,
  input  logic                    dma_rd_done,
  input  logic                    dma_rd_rvalid,
  input  logic [511:0]            dma_rd_rdata,
  output logic                    dma_rd_almostfull,

  output logic [2:0]              region_we,
  output logic [LOG2_DEPTH-1:0]   region_waddr,
  output logic [511:0]            region_wdata,
  input  logic [2:0]              region_almostfull
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_TRIGGER,
    S_READ,
    S_DONE
  } state_t;

  state_t                  state;
  logic [1:0]              pre_cnt;

  // Instruction fields latched at op_start
  logic [CLADDR_WIDTH-1:0] line_addr;
  logic [2:0][31:0]        offsets;
  logic [31:0]             length;
  logic [2:0]              region_mask;
  logic [LOG2_DEPTH-1:0]   bram_base;
  logic [31:0]             count;

  // Decode of the incoming instruction
  logic [CLADDR_WIDTH-1:0] start_addr;
  logic [2:0]              region_onehot;
  logic                    inst_valid;
  logic                    accept;
  logic                    last_line;
  logic                    unused_regs;

  assign start_addr = (regs[3][31] ? in_addr : out_addr)
                    + CLADDR_WIDTH'(regs[3][30:0]);
  assign inst_valid = (regs[4] != 32'd0) && (regs[5][3:0] <= 4'd2);
  assign unused_regs = ^{regs[5][31:4], regs[6][31:LOG2_DEPTH]};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    region_onehot = 3'b000;
    case (regs[5][3:0])
      4'd0:    region_onehot = 3'b001;
      4'd1:    region_onehot = 3'b010;
      4'd2:    region_onehot = 3'b100;
      default: region_onehot = 3'b000;
    endcase
  end

  // A line is taken only while the burst is still short of L lines.
  assign accept    = (state == S_READ) && dma_rd_active && dma_rd_rvalid
                   && (count < length);
  assign last_line = accept && (count == length - 32'd1);

  // NOTE: the instruction latches, line counter and write data carry no reset;
  // they are always loaded before use, so clearing them would only add logic.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && op_start) begin
      line_addr   <= start_addr;
      offsets     <= regs[2:0];
      length      <= regs[4];
      region_mask <= region_onehot;
      bram_base   <= regs[6][LOG2_DEPTH-1:0];
      count       <= 32'd0;
    end else if (state == S_PRE) begin
      // Offsets shift down so each preprocess cycle adds the next one.
      line_addr <= line_addr + CLADDR_WIDTH'(offsets[0]);
      offsets   <= {32'd0, offsets[2:1]};
    end

    if (accept) begin
      region_wdata <= dma_rd_rdata;
      count        <= count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      pre_cnt           <= 2'd0;
      op_done           <= 1'b0;
      dma_rd_start      <= 1'b0;
      dma_rd_addr       <= '0;
      dma_rd_length     <= 32'd0;
      dma_rd_almostfull <= 1'b1;
      region_we         <= 3'b000;
      region_waddr      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // here samples the pre-edge value of every other one.
      op_done           <= 1'b0;
      dma_rd_start      <= 1'b0;
      region_we         <= 3'b000;
      dma_rd_almostfull <= (|(region_almostfull & region_mask))
                         || !dma_rd_active || (state != S_READ);

      if (accept) begin
        region_we    <= region_mask;
        region_waddr <= bram_base + count[LOG2_DEPTH-1:0];
      end

      case (state)
        S_IDLE: begin
          pre_cnt <= 2'd0;
          if (op_start) state <= inst_valid ? S_PRE : S_DONE;
        end

        S_PRE: begin
          pre_cnt <= pre_cnt + 2'd1;
          if (pre_cnt == 2'd2) state <= S_TRIGGER;
        end

        S_TRIGGER: begin
          if (dma_rd_idle) begin
            dma_rd_start  <= 1'b1;
            dma_rd_addr   <= line_addr;
            dma_rd_length <= length;
            state         <= S_READ;
          end
        end

        S_READ: begin
          // Completion pulses here so op_done lines up with the final write.
          if (last_line || dma_rd_done) begin
            op_done <= 1'b1;
            state   <= S_DONE;
          end
        end

        S_DONE: begin
          // Arriving from READ the pulse is already out; from IDLE issue it now.
          op_done <= !op_done;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_glm_load.sv
// Directed bench for glm_load: a scripted DMA feeds lines, expected BRAM writes
// are queued as lines are driven and retired by a write monitor.
module tb_glm_load;

  localparam int CW = 42;
  localparam int LD = 10;

  logic                clk = 1'b0;
  logic                reset;
  logic                op_start;
  logic                op_done;
  logic [6:0][31:0]    regs;
  logic [CW-1:0]       in_addr;
  logic [CW-1:0]       out_addr;
  logic                dma_rd_start;
  logic [CW-1:0]       dma_rd_addr;
  logic [31:0]         dma_rd_length;
  logic                dma_rd_idle;
  logic                dma_rd_active;
  logic                dma_rd_done;
  logic                dma_rd_rvalid;
  logic [511:0]        dma_rd_rdata;
  logic                dma_rd_almostfull;
  logic [2:0]          region_we;
  logic [LD-1:0]       region_waddr;
  logic [511:0]        region_wdata;
  logic [2:0]          region_almostfull;

  glm_load #(.CLADDR_WIDTH(CW), .LOG2_DEPTH(LD)) dut (
    .clk               (clk),
    .reset             (reset),
    .op_start          (op_start),
    .op_done           (op_done),
    .regs              (regs),
    .in_addr           (in_addr),
    .out_addr          (out_addr),
    .dma_rd_start      (dma_rd_start),
    .dma_rd_addr       (dma_rd_addr),
    .dma_rd_length     (dma_rd_length),
    .dma_rd_idle       (dma_rd_idle),
    .dma_rd_active     (dma_rd_active),
    .dma_rd_done       (dma_rd_done),
    .dma_rd_rvalid     (dma_rd_rvalid),
    .dma_rd_rdata      (dma_rd_rdata),
    .dma_rd_almostfull (dma_rd_almostfull),
    .region_we         (region_we),
    .region_waddr      (region_waddr),
    .region_wdata      (region_wdata),
    .region_almostfull (region_almostfull)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    we;
    logic [LD-1:0] waddr;
    logic [511:0]  data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  vectors     = 0;
  int  miscompares = 0;
  int  done_cnt    = 0;
  int  start_cnt   = 0;
  int  d0, s0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor and event counters, sampled on the falling edge.
  always @(negedge clk) begin
    if (op_done === 1'b1) done_cnt++;
    if (dma_rd_start === 1'b1) start_cnt++;
    if (region_we !== 3'b000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 512'(region_we), 512'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_we", 512'(region_we), 512'(mon_e.we));
        check("wr_waddr", 512'(region_waddr), 512'(mon_e.waddr));
        check("wr_data", region_wdata, mon_e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0][31:0] mk(input logic [31:0] r0, r1, r2, r3, r4, r5, r6);
    return {r6, r5, r4, r3, r2, r1, r0};
  endfunction

  function automatic logic [511:0] line_of(input int tag);
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = 32'h5A5A_0000 ^ 32'(tag * 16 + k);
    return d;
  endfunction

  task automatic launch(input logic [6:0][31:0] r);
    regs     = r;
    op_start = 1'b1;
    tick();
    op_start = 1'b0;
  endtask

  // One line on the read channel; its write is expected one cycle later.
  task automatic send_line(input logic [2:0] we, input logic [LD-1:0] wa, input int tag);
    wr_t e;
    e.we    = we;
    e.waddr = wa;
    e.data  = line_of(tag);
    exp_q.push_back(e);
    dma_rd_rvalid = 1'b1;
    dma_rd_rdata  = e.data;
    tick();
    dma_rd_rvalid = 1'b0;
  endtask

  task automatic wait_start(input string tag, input logic [CW-1:0] addr, input logic [31:0] len);
    int n = 0;
    while (dma_rd_start !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_start"}, 512'(dma_rd_start), 512'd1);
    check({tag, "_addr"}, 512'(dma_rd_addr), 512'(addr));
    check({tag, "_len"}, 512'(dma_rd_length), 512'(len));
    dma_rd_idle   = 1'b0;
    dma_rd_active = 1'b1;
  endtask

  task automatic end_burst();
    dma_rd_active = 1'b0;
    dma_rd_idle   = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; op_start = 1'b0; regs = '0;
    in_addr = '0; out_addr = '0;
    dma_rd_idle = 1'b1; dma_rd_active = 1'b0; dma_rd_done = 1'b0;
    dma_rd_rvalid = 1'b0; dma_rd_rdata = '0; region_almostfull = 3'b000;
    tick(); tick();

    check("rst_op_done", 512'(op_done), 512'd0);
    check("rst_start", 512'(dma_rd_start), 512'd0);
    check("rst_we", 512'(region_we), 512'd0);
    check("rst_af", 512'(dma_rd_almostfull), 512'd1);
    check("rst_addr", 512'(dma_rd_addr), 512'd0);
    check("rst_len", 512'(dma_rd_length), 512'd0);
    check("rst_waddr", 512'(region_waddr), 512'd0);
    reset = 1'b0;
    tick();

    // Basic load: exact 5-cycle launch latency, region 1, waddr 8..11
    in_addr  = 42'h1000;
    out_addr = 42'h3_0000_0000;
    d0 = done_cnt; s0 = start_cnt;
    launch(mk(1, 2, 3, 32'h8000_0010, 4, 1, 8));
    repeat (3) tick();
    check("basic_no_early_start", 512'(dma_rd_start), 512'd0);
    tick();
    check("basic_start", 512'(dma_rd_start), 512'd1);
    check("basic_addr", 512'(dma_rd_addr), 512'h1016);
    check("basic_len", 512'(dma_rd_length), 512'd4);
    dma_rd_idle = 1'b0; dma_rd_active = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_line(3'b010, LD'(8 + i), 100 + i);
      if (i == 0) check("basic_af_low", 512'(dma_rd_almostfull), 512'd0);
    end
    check("basic_done", 512'(op_done), 512'd1);
    tick();
    check("basic_done_pulse", 512'(op_done), 512'd0);
    end_burst();
    check("basic_drained", 512'(exp_q.size()), 512'd0);
    check("basic_done_cnt", 512'(done_cnt - d0), 512'd1);
    check("basic_start_cnt", 512'(start_cnt - s0), 512'd1);

    // Zero length: op_done two cycles after op_start, no DMA
    d0 = done_cnt; s0 = start_cnt;
    launch(mk(0, 0, 0, 0, 0, 1, 0));
    check("zl_done_early", 512'(op_done), 512'd0);
    tick();
    check("zl_done", 512'(op_done), 512'd1);
    tick();
    check("zl_done_pulse", 512'(op_done), 512'd0);
    check("zl_no_start", 512'(start_cnt - s0), 512'd0);

    // Invalid region with live read traffic: no start, no writes
    s0 = start_cnt;
    dma_rd_active = 1'b1; dma_rd_rvalid = 1'b1; dma_rd_rdata = line_of(7);
    launch(mk(0, 0, 0, 32'h8000_0000, 5, 3, 0));
    tick();
    check("inv_done", 512'(op_done), 512'd1);
    dma_rd_active = 1'b0; dma_rd_rvalid = 1'b0;
    repeat (3) tick();
    check("inv_no_start", 512'(start_cnt - s0), 512'd0);

    // Backpressure: launch waits on idle; almost-full held ~10 cycles mid-burst
    d0 = done_cnt; s0 = start_cnt;
    dma_rd_idle = 1'b0;
    launch(mk(32'h100, 32'h20, 32'h3, 5, 6, 0, 32'h20));
    repeat (6) tick();
    check("bp_wait_idle", 512'(dma_rd_start), 512'd0);
    dma_rd_idle = 1'b1;
    wait_start("bp", 42'h3_0000_0128, 6);
    send_line(3'b001, 10'h20, 200);
    send_line(3'b001, 10'h21, 201);
    region_almostfull = 3'b001;
    check("bp_af_before", 512'(dma_rd_almostfull), 512'd0);
    tick();
    check("bp_af_rise", 512'(dma_rd_almostfull), 512'd1);
    send_line(3'b001, 10'h22, 202);
    send_line(3'b001, 10'h23, 203);
    op_start = 1'b1;
    tick();
    op_start = 1'b0;
    repeat (5) tick();
    check("bp_af_held", 512'(dma_rd_almostfull), 512'd1);
    region_almostfull = 3'b000;
    tick();
    check("bp_af_fall", 512'(dma_rd_almostfull), 512'd0);
    send_line(3'b001, 10'h24, 204);
    send_line(3'b001, 10'h25, 205);
    check("bp_done", 512'(op_done), 512'd1);
    end_burst();
    check("bp_drained", 512'(exp_q.size()), 512'd0);
    check("bp_done_cnt", 512'(done_cnt - d0), 512'd1);
    check("bp_start_cnt", 512'(start_cnt - s0), 512'd1);

    // Address wrap plus overrun lines after the L-th
    d0 = done_cnt;
    launch(mk(0, 0, 0, 32'h8000_0000, 4, 2, 1022));
    wait_start("wrap", 42'h1000, 4);
    send_line(3'b100, 10'd1022, 300);
    send_line(3'b100, 10'd1023, 301);
    send_line(3'b100, 10'd0, 302);
    send_line(3'b100, 10'd1, 303);
    check("wrap_done", 512'(op_done), 512'd1);
    dma_rd_rvalid = 1'b1; dma_rd_rdata = line_of(399);
    repeat (2) tick();
    dma_rd_rvalid = 1'b0;
    end_burst();
    check("wrap_drained", 512'(exp_q.size()), 512'd0);
    check("wrap_done_cnt", 512'(done_cnt - d0), 512'd1);

    // dma_rd_done together with the final line: one write, one op_done
    d0 = done_cnt;
    launch(mk(0, 0, 0, 32'h8000_0000, 2, 1, 5));
    wait_start("dl", 42'h1000, 2);
    send_line(3'b010, 10'd5, 400);
    dma_rd_done = 1'b1;
    send_line(3'b010, 10'd6, 401);
    dma_rd_done = 1'b0;
    check("dl_done", 512'(op_done), 512'd1);
    end_burst();
    check("dl_drained", 512'(exp_q.size()), 512'd0);
    check("dl_done_cnt", 512'(done_cnt - d0), 512'd1);

    // Early dma_rd_done: transfer ends short of L
    d0 = done_cnt;
    launch(mk(0, 0, 0, 32'h8000_0000, 4, 0, 0));
    wait_start("early", 42'h1000, 4);
    send_line(3'b001, 10'd0, 500);
    dma_rd_done = 1'b1;
    tick();
    dma_rd_done = 1'b0;
    check("early_done", 512'(op_done), 512'd1);
    end_burst();
    check("early_drained", 512'(exp_q.size()), 512'd0);
    check("early_done_cnt", 512'(done_cnt - d0), 512'd1);

    // Reset during READ with a valid line present: no write, no op_done
    d0 = done_cnt;
    launch(mk(0, 0, 0, 32'h8000_0000, 4, 1, 32'h40));
    wait_start("rst", 42'h1000, 4);
    send_line(3'b010, 10'h40, 600);
    send_line(3'b010, 10'h41, 601);
    reset = 1'b1; dma_rd_rvalid = 1'b1; dma_rd_rdata = line_of(602);
    tick();
    check("rst_mid_we", 512'(region_we), 512'd0);
    check("rst_mid_done", 512'(op_done), 512'd0);
    check("rst_mid_af", 512'(dma_rd_almostfull), 512'd1);
    reset = 1'b0; dma_rd_rvalid = 1'b0;
    end_burst();
    check("rst_mid_no_done", 512'(done_cnt - d0), 512'd0);
    launch(mk(0, 0, 0, 0, 0, 0, 0));
    tick();
    check("rst_mid_idle", 512'(op_done), 512'd1);
    repeat (2) tick();
    check("rst_drained", 512'(exp_q.size()), 512'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/glm_load.md
# glm_load

DRAM-to-BRAM load stage of the GLM pipeline. On `op_start` it decodes a 7-register instruction, computes a cache-line DRAM address, launches one DMA read burst, and streams the returned 512-bit lines into one of three on-chip BRAM regions at consecutive addresses. It pulses `op_done` when the transfer completes, so the instruction sequencer can chain it with compute and writeback stages.

## Interface

Parameters:
- `CLADDR_WIDTH`, 42: cache-line address width (`t_claddr`).
- `LOG2_DEPTH`, 10: BRAM region address width.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `op_start`, in, 1: instruction strobe, sampled only in IDLE.
- `op_done`, out, 1: one-cycle completion pulse.
- `regs`, in, 7×32: instruction registers.
- `in_addr`, in, CLADDR_WIDTH: input buffer base.
- `out_addr`, in, CLADDR_WIDTH: output buffer base.
- `dma_rd_start`, out, 1: one-cycle burst launch.
- `dma_rd_addr`, out, CLADDR_WIDTH: burst start line.
- `dma_rd_length`, out, 32: burst length in lines.
- `dma_rd_idle`, in, 1: DMA idle.
- `dma_rd_active`, in, 1: DMA active.
- `dma_rd_done`, in, 1: DMA finished.
- `dma_rd_rvalid`, in, 1: read line valid.
- `dma_rd_rdata`, in, 512: read line data.
- `dma_rd_almostfull`, out, 1: backpressure to DMA, registered.
- `region_we`, out, 3: per-region write enable, one-hot or zero.
- `region_waddr`, out, LOG2_DEPTH: shared write address.
- `region_wdata`, out, 512: shared write data.
- `region_almostfull`, in, 3: per-region almost-full.

## Operation

Instruction decode, latched in IDLE on `op_start`:
- regs[0..2]: line offsets, added to the base.
- regs[3][31] selects the base: 0 = `out_addr`, 1 = `in_addr`. regs[3][30:0] is added to the base. All terms are zero-extended, and the sum wraps modulo 2^CLADDR_WIDTH.
- regs[4]: length L in lines.
- regs[5][3:0]: destination region R.
- regs[6][LOG2_DEPTH-1:0]: BRAM start address A.

State machine:
- IDLE
  - On `op_start`, latch the instruction and clear the counters.
  - If L==0 or R>2, go to DONE with no DMA activity.
  - Otherwise go to PREPROCESS.
- PREPROCESS: takes exactly 3 cycles. Cycle k adds regs[k] to the address. Then go to TRIGGER.
- TRIGGER
  - Wait for `dma_rd_idle`.
  - Then pulse `dma_rd_start` for one cycle with `dma_rd_addr` = computed address and `dma_rd_length` = L.
  - Go to READ.
- READ
  - Each cycle with `dma_rd_active && dma_rd_rvalid` and received count < L: in the next cycle, `region_we[R]`=1, `region_waddr` = A + count (wraps modulo 2^LOG2_DEPTH), `region_wdata` = rdata. Then increment count.
  - Lines arriving with count ≥ L are discarded.
  - Go to DONE on the cycle the L-th line is accepted, or on `dma_rd_done`, whichever comes first.
- DONE: `op_done`=1 for one cycle, then IDLE.

Backpressure:
- `dma_rd_almostfull` is registered: `region_almostfull[R] || !dma_rd_active || state != READ`.
- The region almost-full threshold must absorb at least 2 in-flight lines. The block never drops a valid line accepted in READ.

## Timing

- Reset values:
  - `op_done`, `dma_rd_start`, `region_we` = 0.
  - `dma_rd_almostfull` = 1.
  - `dma_rd_addr`, `dma_rd_length`, `region_waddr` = 0.
  - State = IDLE.
- Reset mid-transfer returns to IDLE next cycle. No `op_done` is issued.
- Minimum `op_start`→`dma_rd_start` latency is 5 cycles (IDLE, 3×PREPROCESS, TRIGGER) when `dma_rd_idle` is already high.
- `rvalid`→`region_we` latency is 1 cycle.
- The last accepted line at cycle t gives `region_we` at t+1 and `op_done` at t+1.
- L==0 or invalid R: `op_done` 2 cycles after `op_start`.
- `op_start` outside IDLE is ignored.
- `dma_rd_done` and the final line in the same cycle: the line is written and a single `op_done` is issued.
- All outputs except `region_wdata` are registered; `region_wdata` is held when `we`=0.

## Test plan

- **Basic load:** regs = {1,2,3, 0x80000010, 4, 1, 8}, `in_addr`=0x1000, DMA idle.
  - `dma_rd_start` at cycle 5 with addr 0x1016, length 4.
  - 4 rdata lines give `region_we`=3'b010 at waddr 8–11.
  - One `op_done`.
- **Zero length:** regs[4]=0. `op_done` 2 cycles after `op_start`; `dma_rd_start` never asserts.
- **Invalid region:** regs[5]=3, L=5. `op_done` with no DMA start and no `region_we`.
- **Backpressure:** `region_almostfull[0]` held high mid-burst for 10 cycles.
  - `dma_rd_almostfull` rises 1 cycle later.
  - No line lost; all L lines written in order.
- **Address wrap:** A = 2^LOG2_DEPTH−2, L=4. waddr sequence is 1022, 1023, 0, 1.
- **Reset and overrun:**
  - Reset during READ: `region_we`=0 next cycle, IDLE, no `op_done`.
  - Extra rvalid after L lines: ignored.
